// File: rtl/t_ff_sched_pkg.sv
// Shared types and default widths for the t_ff toggle sequencer.
package t_ff_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

    localparam int CNT_W_DEF = 8;
    localparam int GAP_W_DEF = 4;

endpackage

// File: rtl/t_ff.sv
// Toggle flip-flop driven by the sequencer: q flips on every clock edge where t is high.
module t_ff (
    input  logic clk,
    input  logic reset_n,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule

// File: rtl/t_ff_toggle_sched.sv
// Issues a programmed number of single-cycle t pulses with a programmable gap,
// mirroring the driven t_ff state and flagging any q feedback disagreement.
module t_ff_toggle_sched
    import t_ff_sched_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int GAP_W    = GAP_W_DEF,
    parameter bit CHECK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_toggles,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    input  logic             q_fb,
    output logic             t,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] toggle_cnt
);

    sched_state_e     state_q, state_d;
    logic             t_q, t_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             exp_q_q, exp_q_d;
    logic [CNT_W-1:0] toggle_cnt_q, toggle_cnt_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [GAP_W-1:0] gap_lat_q, gap_lat_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            t_q          <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            exp_q_q      <= 1'b0;
            toggle_cnt_q <= '0;
            remaining_q  <= '0;
            gap_lat_q    <= '0;
            gap_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            t_q          <= t_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            exp_q_q      <= exp_q_d;
            toggle_cnt_q <= toggle_cnt_d;
            remaining_q  <= remaining_d;
            gap_lat_q    <= gap_lat_d;
            gap_cnt_q    <= gap_cnt_d;
        end
    end

    // Outputs are computed for the next state so that t/busy/done are registered.
    always_comb begin
        state_d      = state_q;
        t_d          = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        err_d        = err_q;
        exp_q_d      = exp_q_q ^ t_q;
        toggle_cnt_d = toggle_cnt_q;
        remaining_d  = remaining_q;
        gap_lat_d    = gap_lat_q;
        gap_cnt_d    = gap_cnt_q;

        if (CHECK_EN && (q_fb != exp_q_q)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    err_d        = 1'b0;
                    toggle_cnt_d = '0;
                    if (num_toggles != '0) begin
                        remaining_d = num_toggles;
                        gap_lat_d   = gap;
                        state_d     = PULSE;
                        t_d         = 1'b1;
                        busy_d      = 1'b1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            PULSE: begin
                // The pulse in flight is already seen by the t_ff, so count it even on abort.
                toggle_cnt_d = toggle_cnt_q + CNT_W'(1);
                remaining_d  = remaining_q - CNT_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (remaining_q == CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else if (gap_lat_q == '0) begin
                    state_d = PULSE;
                    t_d     = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d   = GAP;
                    gap_cnt_d = gap_lat_q;
                    busy_d    = 1'b1;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
                if (abort) begin
                    state_d = IDLE;
                end else if (gap_cnt_q == GAP_W'(1)) begin
                    state_d = PULSE;
                    t_d     = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    busy_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!CHECK_EN) begin
            err_d = 1'b0;
        end
    end

    assign t          = t_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign toggle_cnt = toggle_cnt_q;

endmodule

// File: tb/tb_t_ff_toggle_sched.sv
// Scoreboard bench for t_ff_toggle_sched driving a real t_ff instance.
module tb_t_ff_toggle_sched;

    typedef struct {
        logic        done;
        logic [7:0]  cnt;
        logic        err;
        logic        q;
        int          len;
        logic [63:0] pat;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] num_toggles;
    logic [3:0] gap;
    logic       abort;
    logic       q_fb;
    logic       t;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] toggle_cnt;
    logic       tff_q;
    logic       inject;

    int n_compared;
    int n_mismatched;

    exp_t sb_q[$];

    logic        busy_prev;
    int          mon_len;
    logic [63:0] mon_pat;

    t_ff_toggle_sched #(
        .CNT_W    (8),
        .GAP_W    (4),
        .CHECK_EN (1'b1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_toggles (num_toggles),
        .gap         (gap),
        .abort       (abort),
        .q_fb        (q_fb),
        .t           (t),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .toggle_cnt  (toggle_cnt)
    );

    t_ff u_tff (
        .clk     (clk),
        .reset_n (reset_n),
        .t       (t),
        .q       (tff_q)
    );

    assign q_fb = tff_q ^ inject;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_compared++;
        if (act !== expv) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Queue the expected completion record, then present the command for one cycle.
    task automatic applyStimulus(input logic [7:0] n, input logic [3:0] g,
                                 input logic e_done, input logic [7:0] e_cnt,
                                 input logic e_err, input logic e_q,
                                 input int e_len, input logic [63:0] e_pat);
        exp_t e;
        e.done = e_done;
        e.cnt  = e_cnt;
        e.err  = e_err;
        e.q    = e_q;
        e.len  = e_len;
        e.pat  = e_pat;
        sb_q.push_back(e);
        @(negedge clk);
        start       = 1'b1;
        num_toggles = n;
        gap         = g;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy && !done) return;
        end
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s_timeout: busy=%0b done=%0b, expected idle within 200 cycles", name, busy, done);
    endtask

    // Monitor: collects t over the busy window and retires one scoreboard entry
    // whenever a command ends (done pulse, or busy dropping without done on abort).
    always @(negedge clk) begin
        exp_t e;
        if (!reset_n) begin
            busy_prev = 1'b0;
            mon_len   = 0;
            mon_pat   = '0;
        end else begin
            if (busy) begin
                if (mon_len < 64) mon_pat[mon_len] = t;
                mon_len++;
            end
            if (done || (busy_prev && !busy)) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL unexpected_response: done=%0b toggle_cnt=%0d, expected no response", done, toggle_cnt);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("done",       {63'd0, done},       {63'd0, e.done});
                    checkOutput("toggle_cnt", {56'd0, toggle_cnt}, {56'd0, e.cnt});
                    checkOutput("err",        {63'd0, err},        {63'd0, e.err});
                    checkOutput("q",          {63'd0, tff_q},      {63'd0, e.q});
                    checkOutput("busy_len",   64'(mon_len),        64'(e.len));
                    checkOutput("t_pattern",  mon_pat,             e.pat);
                end
                mon_len = 0;
                mon_pat = '0;
            end
            busy_prev = busy;
        end
    end

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        num_toggles = '0;
        gap         = '0;
        abort       = 1'b0;
        inject      = 1'b0;
        n_compared   = 0;
        n_mismatched = 0;

        #12;
        checkOutput("rst_t",          {63'd0, t},          64'd0);
        checkOutput("rst_busy",       {63'd0, busy},       64'd0);
        checkOutput("rst_done",       {63'd0, done},       64'd0);
        checkOutput("rst_err",        {63'd0, err},        64'd0);
        checkOutput("rst_toggle_cnt", {56'd0, toggle_cnt}, 64'd0);
        #3 reset_n = 1'b1;

        // Back-to-back pulses: q 0 -> 0 after four toggles.
        applyStimulus(8'd4, 4'd0, 1'b1, 8'd4, 1'b0, 1'b0, 4, 64'b1111);
        wait_idle("n4_g0");

        // Two idle cycles between pulses: q 0 -> 1.
        applyStimulus(8'd3, 4'd2, 1'b1, 8'd3, 1'b0, 1'b1, 7, 64'b1001001);
        wait_idle("n3_g2");

        // Zero-length command: done only, no busy, q unchanged.
        applyStimulus(8'd0, 4'd5, 1'b1, 8'd0, 1'b0, 1'b1, 0, 64'd0);
        wait_idle("n0");

        // Abort sampled during the third pulse: 3 counted, q 1 -> 0.
        applyStimulus(8'd10, 4'd1, 1'b0, 8'd3, 1'b0, 1'b0, 5, 64'b10101);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_t",    {63'd0, t},    64'd0);
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        wait_idle("abort");

        // A second start while busy must be ignored: five pulses, q 0 -> 1.
        applyStimulus(8'd5, 4'd1, 1'b1, 8'd5, 1'b0, 1'b1, 9, 64'b101010101);
        @(negedge clk);
        start       = 1'b1;
        num_toggles = 8'd7;
        gap         = 4'd0;
        @(negedge clk);
        start = 1'b0;
        wait_idle("restart_ignored");

        // One cycle of corrupted feedback: err sticks through done, q 1 -> 1.
        applyStimulus(8'd4, 4'd1, 1'b1, 8'd4, 1'b1, 1'b1, 7, 64'b1010101);
        repeat (2) @(negedge clk);
        inject = 1'b1;
        @(negedge clk);
        inject = 1'b0;
        wait_idle("err_inject");

        // Next accepted start clears err.
        applyStimulus(8'd2, 4'd0, 1'b1, 8'd2, 1'b0, 1'b1, 2, 64'b11);
        checkOutput("err_cleared", {63'd0, err}, 64'd0);
        wait_idle("after_err");

        // Reset during a gap returns everything to zero immediately.
        applyStimulus(8'd6, 4'd3, 1'b0, 8'd0, 1'b0, 1'b0, 0, 64'd0);
        void'(sb_q.pop_back());
        @(negedge clk);
        checkOutput("gap_busy", {63'd0, busy}, 64'd1);
        checkOutput("gap_t",    {63'd0, t},    64'd0);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midrst_t",          {63'd0, t},          64'd0);
        checkOutput("midrst_busy",       {63'd0, busy},       64'd0);
        checkOutput("midrst_done",       {63'd0, done},       64'd0);
        checkOutput("midrst_err",        {63'd0, err},        64'd0);
        checkOutput("midrst_toggle_cnt", {56'd0, toggle_cnt}, 64'd0);
        checkOutput("midrst_q",          {63'd0, tff_q},      64'd0);
        @(negedge clk);
        #2 reset_n = 1'b1;

        // Recovery after reset: single pulse, q 0 -> 1.
        applyStimulus(8'd1, 4'd0, 1'b1, 8'd1, 1'b0, 1'b1, 1, 64'b1);
        wait_idle("post_reset");

        repeat (3) @(negedge clk);
        while (sb_q.size() != 0) begin
            exp_t e;
            e = sb_q.pop_front();
            n_compared++;
            n_mismatched++;
            $display("[TB] FAIL missing_response: got none, expected toggle_cnt=%0d done=%0b", e.cnt, e.done);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
